// File: rtl/makina_pkg.sv
// Shared encodings and the decoded control bundle for the Makina 16-bit ISA.
// Register indices and immediates are parameter-sized, so they travel beside this bundle.
package makina_pkg;

    typedef enum logic [1:0] {
        CLS_MEM = 2'b00,
        CLS_ALU = 2'b01,
        CLS_JMP = 2'b10,
        CLS_ILL = 2'b11
    } cls_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LI  = 4'b1010;
    localparam logic [2:0] CMP_JMP = 3'b110;
    localparam logic [2:0] CMP_NOP = 3'b111;

    typedef struct packed {
        logic [1:0] cls;
        logic [3:0] alu_ctrl;
        logic [2:0] cmp_ctrl;
        logic       alu_src_imm;
        logic       reg_write;
        logic       wb_sel;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    // A load is the only mem-class instruction that writes a register.
    function automatic logic is_load(input ctrl_t c);
        is_load = (c.cls == CLS_MEM) && c.reg_write;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational field decode: instruction word to control bundle, operands,
// extended immediate and the set of registers the instruction reads.
module decode_fields
    import makina_pkg::*;
#(
    parameter int XLEN     = 16,
    parameter int REG_AW   = 3,
    parameter int SIGN_EXT = 0
) (
    input  logic [15:0]       instr_i,
    output ctrl_t             ctrl_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [XLEN-1:0]   imm_o,
    output logic              rs1_used_o,
    output logic              rs2_used_o,
    output logic              rd_used_o
);

    function automatic logic [XLEN-1:0] ext7(input logic [6:0] f);
        if (SIGN_EXT != 0) begin
            ext7 = {{(XLEN-7){f[6]}}, f};
        end else begin
            ext7 = {{(XLEN-7){1'b0}}, f};
        end
    endfunction

    function automatic logic [XLEN-1:0] ext6(input logic [5:0] f);
        if (SIGN_EXT != 0) begin
            ext6 = {{(XLEN-6){f[5]}}, f};
        end else begin
            ext6 = {{(XLEN-6){1'b0}}, f};
        end
    endfunction

    // Per-class field extraction; anything not named by a class stays zero.
    always_comb begin
        ctrl_o     = '0;
        rd_o       = '0;
        rs1_o      = '0;
        rs2_o      = '0;
        imm_o      = '0;
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        rd_used_o  = 1'b0;
        ctrl_o.cls = instr_i[15:14];
        case (cls_e'(instr_i[15:14]))
            CLS_MEM: begin
                ctrl_o.alu_ctrl    = ALU_ADD;
                ctrl_o.alu_src_imm = 1'b1;
                rd_o               = REG_AW'(instr_i[12:10]);
                rs1_o              = REG_AW'(instr_i[9:7]);
                imm_o              = ext7(instr_i[6:0]);
                rs1_used_o         = 1'b1;
                if (instr_i[13]) begin
                    ctrl_o.mem_write = 1'b1;
                    rs2_o            = REG_AW'(instr_i[12:10]);
                    rs2_used_o       = 1'b1;
                end else begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.wb_sel    = 1'b1;
                end
            end
            CLS_ALU: begin
                ctrl_o.alu_ctrl  = instr_i[13:10];
                ctrl_o.reg_write = 1'b1;
                rd_o             = REG_AW'(instr_i[8:6]);
                rs1_o            = REG_AW'(instr_i[5:3]);
                rs2_o            = REG_AW'(instr_i[2:0]);
                if (instr_i[13:10] == ALU_LI) begin
                    ctrl_o.alu_src_imm = 1'b1;
                    imm_o              = ext6(instr_i[5:0]);
                end else begin
                    rs1_used_o = 1'b1;
                    rs2_used_o = 1'b1;
                end
            end
            CLS_JMP: begin
                ctrl_o.cmp_ctrl = instr_i[13:11];
                if (instr_i[13:11] == CMP_NOP) begin
                    ctrl_o.cmp_ctrl = CMP_NOP;
                end else if (instr_i[13:11] == CMP_JMP) begin
                    rd_o      = REG_AW'(instr_i[4:2]);
                    rd_used_o = 1'b1;
                end else begin
                    rs1_o      = REG_AW'(instr_i[10:8]);
                    rs2_o      = REG_AW'(instr_i[7:5]);
                    rs1_used_o = 1'b1;
                    rs2_used_o = 1'b1;
                end
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage: output register, load-use scoreboard,
// stall and flush handling around decode_fields.
module decode_stage
    import makina_pkg::*;
#(
    parameter int XLEN     = 16,
    parameter int REG_AW   = 3,
    parameter int SIGN_EXT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_class,
    output logic [3:0]           out_alu_ctrl,
    output logic [2:0]           out_cmp_ctrl,
    output logic [REG_AW-1:0]    out_rd,
    output logic [REG_AW-1:0]    out_rs1,
    output logic [REG_AW-1:0]    out_rs2,
    output logic [XLEN-1:0]      out_imm_se,
    output logic                 out_alu_src_imm,
    output logic                 out_reg_write,
    output logic                 out_wb_sel,
    output logic                 out_mem_write,
    output logic                 out_illegal,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_rd,
    output logic [2**REG_AW-1:0] sb_busy
);

    localparam int NREG = 2**REG_AW;

    ctrl_t             dec_ctrl_s;
    logic [REG_AW-1:0] dec_rd_s, dec_rs1_s, dec_rs2_s;
    logic [XLEN-1:0]   dec_imm_s;
    logic              rs1_used_s, rs2_used_s, rd_used_s;

    decode_fields #(.XLEN(XLEN), .REG_AW(REG_AW), .SIGN_EXT(SIGN_EXT)) u_fields (
        .instr_i    (in_instr),
        .ctrl_o     (dec_ctrl_s),
        .rd_o       (dec_rd_s),
        .rs1_o      (dec_rs1_s),
        .rs2_o      (dec_rs2_s),
        .imm_o      (dec_imm_s),
        .rs1_used_o (rs1_used_s),
        .rs2_used_o (rs2_used_s),
        .rd_used_o  (rd_used_s)
    );

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [NREG-1:0]   sb_q, sb_d;

    logic              ld_handoff_s, hazard_s, accept_s;
    logic [NREG-1:0]   wb_clr_s, sb_eff_s, sb_set_s;

    // A writeback this cycle already frees its register for the hazard check.
    always_comb begin
        ld_handoff_s = valid_q & out_ready & is_load(ctrl_q);
        wb_clr_s     = wb_valid ? (NREG'(1) << wb_rd) : '0;
        sb_eff_s     = sb_q & ~wb_clr_s;
        sb_set_s     = (ld_handoff_s & ~flush) ? (NREG'(1) << rd_q) : '0;
        hazard_s     = in_valid & (
            (rs1_used_s & (sb_eff_s[dec_rs1_s] | (ld_handoff_s & (dec_rs1_s == rd_q)))) |
            (rs2_used_s & (sb_eff_s[dec_rs2_s] | (ld_handoff_s & (dec_rs2_s == rd_q)))) |
            (rd_used_s  & (sb_eff_s[dec_rd_s]  | (ld_handoff_s & (dec_rd_s  == rd_q)))));
        in_ready     = (~valid_q | out_ready) & ~hazard_s & ~flush;
        accept_s     = in_valid & in_ready;
        sb_d         = sb_eff_s | sb_set_s;
    end

    // Output-register next state: flush, load, bubble or hold.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl_s;
            rd_d    = dec_rd_s;
            rs1_d   = dec_rs1_s;
            rs2_d   = dec_rs2_s;
            imm_d   = dec_imm_s;
        end else if (valid_q & out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            sb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            sb_q    <= sb_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_class       = ctrl_q.cls;
    assign out_alu_ctrl    = ctrl_q.alu_ctrl;
    assign out_cmp_ctrl    = ctrl_q.cmp_ctrl;
    assign out_rd          = rd_q;
    assign out_rs1         = rs1_q;
    assign out_rs2         = rs2_q;
    assign out_imm_se      = imm_q;
    assign out_alu_src_imm = ctrl_q.alu_src_imm;
    assign out_reg_write   = ctrl_q.reg_write;
    assign out_wb_sel      = ctrl_q.wb_sel;
    assign out_mem_write   = ctrl_q.mem_write;
    assign out_illegal     = ctrl_q.illegal;
    assign sb_busy         = sb_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: zero-extending main DUT plus a sign-extending twin.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready, wb_valid;
    logic [15:0] in_instr;
    logic [2:0]  wb_rd;

    logic        in_ready, out_valid, out_alu_src_imm, out_reg_write, out_wb_sel, out_mem_write, out_illegal;
    logic [1:0]  out_class;
    logic [3:0]  out_alu_ctrl;
    logic [2:0]  out_cmp_ctrl, out_rd, out_rs1, out_rs2;
    logic [15:0] out_imm_se;
    logic [7:0]  sb_busy;

    logic        se_in_ready, se_out_valid, se_src_imm, se_reg_write, se_wb_sel, se_mem_write, se_illegal;
    logic [1:0]  se_class;
    logic [3:0]  se_alu_ctrl;
    logic [2:0]  se_cmp_ctrl, se_rd, se_rs1, se_rs2;
    logic [15:0] se_imm;
    logic [7:0]  se_sb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(16), .REG_AW(3), .SIGN_EXT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_alu_ctrl(out_alu_ctrl), .out_cmp_ctrl(out_cmp_ctrl),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm_se(out_imm_se),
        .out_alu_src_imm(out_alu_src_imm), .out_reg_write(out_reg_write),
        .out_wb_sel(out_wb_sel), .out_mem_write(out_mem_write), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .sb_busy(sb_busy)
    );

    decode_stage #(.XLEN(16), .REG_AW(3), .SIGN_EXT(1)) dut_se (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(se_in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(se_out_valid), .out_ready(out_ready),
        .out_class(se_class), .out_alu_ctrl(se_alu_ctrl), .out_cmp_ctrl(se_cmp_ctrl),
        .out_rd(se_rd), .out_rs1(se_rs1), .out_rs2(se_rs2), .out_imm_se(se_imm),
        .out_alu_src_imm(se_src_imm), .out_reg_write(se_reg_write),
        .out_wb_sel(se_wb_sel), .out_mem_write(se_mem_write), .out_illegal(se_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .sb_busy(se_sb_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ne();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; flush = 1'b0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 3'd0;
        repeat (2) cyc();
        ne();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sb", 32'(sb_busy), 32'd0);
        chk("rst_imm", 32'(out_imm_se), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst_n = 1'b1;

        // ADD r3,r1,r2
        in_valid = 1'b1; in_instr = 16'h40CA;
        ne(); chk("add_in_ready", 32'(in_ready), 32'd1);
        cyc(); in_valid = 1'b0;
        ne();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_fields", {20'd0, 2'(out_class), 1'(out_reg_write), out_rd, out_rs1, out_rs2},
            {20'd0, 2'd1, 1'b1, 3'd3, 3'd1, 3'd2});
        cyc(); ne(); chk("add_bubble", 32'(out_valid), 32'd0);

        // LD r2,5(r1) then ADD r4,r2,r0: stall until wb of r2
        cyc(); in_valid = 1'b1; in_instr = 16'h0885;
        cyc(); in_instr = 16'h4110;
        ne();
        chk("ld_fields", {24'd0, 1'(out_reg_write), 1'(out_wb_sel), 1'(out_mem_write), out_rd, 2'b0},
            {24'd0, 1'b1, 1'b1, 1'b0, 3'd2, 2'b0});
        chk("ld_imm", 32'(out_imm_se), 32'h5);
        chk("fwd_hazard", 32'(in_ready), 32'd0);
        cyc(); ne();
        chk("sb_set_r2", 32'(sb_busy), 32'h04);
        chk("stall_1", 32'(in_ready), 32'd0);
        cyc(); ne(); chk("stall_2", 32'(in_ready), 32'd0);
        cyc(); wb_valid = 1'b1; wb_rd = 3'd2;
        ne(); chk("wb_release", 32'(in_ready), 32'd1);
        cyc(); wb_valid = 1'b0; in_valid = 1'b0;
        ne();
        chk("add2_valid", 32'(out_valid), 32'd1);
        chk("add2_regs", {26'd0, out_rd, out_rs1}, {26'd0, 3'd4, 3'd2});
        chk("sb_cleared", 32'(sb_busy), 32'd0);

        // LD r0,127(r0): zero- versus sign-extension, then retire the load
        cyc(); in_valid = 1'b1; in_instr = 16'h007F;
        cyc(); in_valid = 1'b0;
        ne();
        chk("ld_imm_ze", 32'(out_imm_se), 32'h007F);
        chk("ld_imm_se", 32'(se_imm), 32'hFFFF);
        cyc(); wb_valid = 1'b1; wb_rd = 3'd0;
        cyc(); wb_valid = 1'b0;
        ne(); chk("sb_r0_clear", {16'd0, sb_busy, se_sb_busy}, 32'd0);

        // LI r1,0x3F ; ST r2,3(r1) ; JMP r3
        cyc(); in_valid = 1'b1; in_instr = 16'h687F;
        cyc(); in_instr = 16'h2883;
        ne();
        chk("li_imm_ze", 32'(out_imm_se), 32'h003F);
        chk("li_imm_se", 32'(se_imm), 32'hFFFF);
        chk("li_ctrl", {26'd0, out_alu_ctrl, 1'(out_alu_src_imm), 1'(out_reg_write)},
            {26'd0, 4'b1010, 1'b1, 1'b1});
        cyc(); in_instr = 16'hB00C;
        ne();
        chk("st_ctrl", {29'd0, 1'(out_mem_write), 1'(out_reg_write), 1'(out_alu_src_imm)},
            {29'd0, 1'b1, 1'b0, 1'b1});
        chk("st_regs", {20'd0, out_rd, out_rs1, out_rs2, 3'd0}, {20'd0, 3'd2, 3'd1, 3'd2, 3'd0});
        cyc(); in_valid = 1'b0;
        ne();
        chk("jmp_fields", {24'd0, out_cmp_ctrl, out_rd, 1'(out_reg_write), 1'(out_mem_write)},
            {24'd0, 3'd6, 3'd3, 1'b0, 1'b0});

        // Backpressure: A held 3 cycles, B follows exactly once
        cyc(); in_valid = 1'b1; in_instr = 16'h40CA;
        cyc(); in_instr = 16'h4110; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ne();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_rd", 32'(out_rd), 32'd3);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        ne(); chk("release_in_ready", 32'(in_ready), 32'd1);
        cyc(); in_valid = 1'b0;
        ne();
        chk("next_valid", 32'(out_valid), 32'd1);
        chk("next_rd", 32'(out_rd), 32'd4);
        cyc(); ne(); chk("no_dup", 32'(out_valid), 32'd0);

        // Flush while a LD r5 hands off, with another word offered
        cyc(); in_valid = 1'b1; in_instr = 16'h1400;
        cyc(); in_instr = 16'h40CA; flush = 1'b1;
        ne(); chk("flush_in_ready", 32'(in_ready), 32'd0);
        cyc(); flush = 1'b0; in_valid = 1'b0;
        ne();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_sb", 32'(sb_busy), 32'd0);

        // Illegal word
        cyc(); in_valid = 1'b1; in_instr = 16'hC000;
        ne(); chk("ill_in_ready", 32'(in_ready), 32'd1);
        cyc(); in_valid = 1'b0;
        ne();
        chk("ill_flags", {27'd0, out_class, 1'(out_illegal), 1'(out_reg_write), 1'(out_mem_write)},
            {27'd0, 2'd3, 1'b1, 1'b0, 1'b0});

        // LD r5 sets sb[5]; illegal never stalls on it; set beats same-cycle clear
        cyc(); in_valid = 1'b1; in_instr = 16'h1400;
        cyc(); in_valid = 1'b0;
        cyc();
        ne(); chk("sb_r5", 32'(sb_busy), 32'h20);
        in_valid = 1'b1; in_instr = 16'hC000;
        ne(); chk("ill_no_stall", 32'(in_ready), 32'd1);
        cyc(); in_instr = 16'h1400;
        cyc(); in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 3'd5;
        cyc(); wb_valid = 1'b0;
        ne(); chk("set_wins", 32'(sb_busy), 32'h20);

        // Asynchronous reset mid-operation
        cyc(); in_valid = 1'b1; in_instr = 16'h40CA;
        cyc(); rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sb", 32'(sb_busy), 32'd0);
        in_valid = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
